// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap sequencer beside writeback.
//
// Holds mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mtval, the mcycle and
// minstret counters and mcountinhibit. Exceptions, interrupts and mret are
// committed in RUN and hand a target PC to fetch through a redirect handshake.
module csr_trap_unit #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned NUM_LOCAL_IRQ = 4,
  parameter int unsigned VECTORED_EN   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic [11:0]              i_csr_ra,
  output logic [XLEN-1:0]          o_csr_rd,
  output logic                     o_csr_ill,
  input  logic                     i_csr_we,
  input  logic [11:0]              i_csr_wa,
  input  logic [XLEN-1:0]          i_csr_wd,
  input  logic                     i_retire,
  input  logic                     i_exc_valid,
  input  logic [3:0]               i_exc_cause,
  input  logic [XLEN-1:0]          i_exc_pc,
  input  logic [XLEN-1:0]          i_exc_tval,
  input  logic [XLEN-1:0]          i_int_pc,
  input  logic                     i_mret,
  input  logic                     i_trint,
  input  logic                     i_swint,
  input  logic                     i_exint,
  input  logic [NUM_LOCAL_IRQ-1:0] i_lirq,
  input  logic                     i_stall,
  output logic                     o_redirect_valid,
  output logic [XLEN-1:0]          o_redirect_pc,
  input  logic                     i_redirect_ready,
  output logic                     o_int_pending,
  output logic [1:0]               o_priv
);

  localparam logic [11:0] AddrMstatus  = 12'h300;
  localparam logic [11:0] AddrMie      = 12'h304;
  localparam logic [11:0] AddrMtvec    = 12'h305;
  localparam logic [11:0] AddrMcntinh  = 12'h320;
  localparam logic [11:0] AddrMscratch = 12'h340;
  localparam logic [11:0] AddrMepc     = 12'h341;
  localparam logic [11:0] AddrMcause   = 12'h342;
  localparam logic [11:0] AddrMtval    = 12'h343;
  localparam logic [11:0] AddrMip      = 12'h344;
  localparam logic [11:0] AddrMcycle   = 12'hB00;
  localparam logic [11:0] AddrMinstret = 12'hB02;

  localparam logic [1:0] PrivM = 2'd3;

  // Writable mie bits: software, timer, external and the local lines at 16+.
  localparam logic [XLEN-1:0] LocalMask =
    {{(XLEN-NUM_LOCAL_IRQ){1'b0}}, {NUM_LOCAL_IRQ{1'b1}}} << 16;
  localparam logic [XLEN-1:0] MieMask = LocalMask | XLEN'(12'h888);

  typedef enum logic [0:0] {StRun, StRedirect} state_e;

  // Registered state
  state_e                   r_state;
  logic [1:0]               r_priv;
  logic                     r_mstatus_mie;
  logic                     r_mstatus_mpie;
  logic [1:0]               r_mstatus_mpp;
  logic [XLEN-1:0]          r_mie;
  logic                     r_mip_sw;
  logic                     r_mip_tm;
  logic                     r_mip_ex;
  logic [NUM_LOCAL_IRQ-1:0] r_mip_loc;
  logic [XLEN-1:0]          r_mtvec;
  logic [XLEN-1:0]          r_mscratch;
  logic [XLEN-1:0]          r_mepc;
  logic [XLEN-1:0]          r_mcause;
  logic [XLEN-1:0]          r_mtval;
  logic [XLEN-1:0]          r_mcycle;
  logic [XLEN-1:0]          r_minstret;
  logic                     r_cy_inh;
  logic                     r_ir_inh;
  logic [XLEN-1:0]          r_redirect_pc;

  // Next-state
  state_e                   w_state_d;
  logic [1:0]               w_priv_d;
  logic                     w_mstatus_mie_d;
  logic                     w_mstatus_mpie_d;
  logic [1:0]               w_mstatus_mpp_d;
  logic [XLEN-1:0]          w_mie_d;
  logic [XLEN-1:0]          w_mtvec_d;
  logic [XLEN-1:0]          w_mscratch_d;
  logic [XLEN-1:0]          w_mepc_d;
  logic [XLEN-1:0]          w_mcause_d;
  logic [XLEN-1:0]          w_mtval_d;
  logic [XLEN-1:0]          w_mcycle_d;
  logic [XLEN-1:0]          w_minstret_d;
  logic                     w_cy_inh_d;
  logic                     w_ir_inh_d;
  logic [XLEN-1:0]          w_redirect_pc_d;

  // Decoded views
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mcntinh;
  logic [XLEN-1:0] w_irq_pend;
  logic            w_int_pending;
  logic [4:0]      w_int_code;
  logic [XLEN-1:0] w_base;
  logic [XLEN-1:0] w_int_target;
  logic            w_commit_ok;
  logic            w_take_exc;
  logic            w_take_int;
  logic            w_take_mret;
  logic            w_csr_wr;

  always_comb begin
    w_mip                       = '0;
    w_mip[3]                    = r_mip_sw;
    w_mip[7]                    = r_mip_tm;
    w_mip[11]                   = r_mip_ex;
    w_mip[16 +: NUM_LOCAL_IRQ]  = r_mip_loc;

    w_mstatus                   = '0;
    w_mstatus[3]                = r_mstatus_mie;
    w_mstatus[7]                = r_mstatus_mpie;
    w_mstatus[12:11]            = r_mstatus_mpp;

    w_mcntinh                   = '0;
    w_mcntinh[0]                = r_cy_inh;
    w_mcntinh[2]                = r_ir_inh;
  end

  assign w_irq_pend    = w_mip & r_mie;
  assign w_int_pending = (r_mstatus_mie | (r_priv != PrivM)) & (|w_irq_pend);

  // Source priority 11 > 3 > 7 > highest local; later assignments win.
  always_comb begin
    w_int_code = 5'd0;
    for (int unsigned i = 0; i < NUM_LOCAL_IRQ; i++) begin
      if (w_irq_pend[16 + i]) w_int_code = 5'(16 + i);
    end
    if (w_irq_pend[7])  w_int_code = 5'd7;
    if (w_irq_pend[3])  w_int_code = 5'd3;
    if (w_irq_pend[11]) w_int_code = 5'd11;
  end

  assign w_base       = {r_mtvec[XLEN-1:2], 2'b00};
  assign w_int_target = r_mtvec[0] ? (w_base + XLEN'({w_int_code, 2'b00})) : w_base;

  // Commit arbitration: exception > interrupt > mret > CSR write.
  assign w_commit_ok = (r_state == StRun) & ~i_stall;
  assign w_take_exc  = w_commit_ok & i_exc_valid;
  assign w_take_int  = w_commit_ok & ~i_exc_valid & w_int_pending;
  assign w_take_mret = w_commit_ok & ~i_exc_valid & ~w_int_pending & i_mret;
  assign w_csr_wr    = w_commit_ok & ~i_exc_valid & ~w_int_pending & ~i_mret & i_csr_we;

  // CSR read mux
  always_comb begin
    o_csr_rd  = '0;
    o_csr_ill = 1'b0;
    case (i_csr_ra)
      AddrMstatus:  o_csr_rd = w_mstatus;
      AddrMie:      o_csr_rd = r_mie;
      AddrMtvec:    o_csr_rd = r_mtvec;
      AddrMcntinh:  o_csr_rd = w_mcntinh;
      AddrMscratch: o_csr_rd = r_mscratch;
      AddrMepc:     o_csr_rd = r_mepc;
      AddrMcause:   o_csr_rd = r_mcause;
      AddrMtval:    o_csr_rd = r_mtval;
      AddrMip:      o_csr_rd = w_mip;
      AddrMcycle:   o_csr_rd = r_mcycle;
      AddrMinstret: o_csr_rd = r_minstret;
      default:      o_csr_ill = 1'b1;
    endcase
  end

  // Next-state: FSM, trap sequencing, CSR writes and counters
  always_comb begin
    w_state_d        = r_state;
    w_priv_d         = r_priv;
    w_mstatus_mie_d  = r_mstatus_mie;
    w_mstatus_mpie_d = r_mstatus_mpie;
    w_mstatus_mpp_d  = r_mstatus_mpp;
    w_mie_d          = r_mie;
    w_mtvec_d        = r_mtvec;
    w_mscratch_d     = r_mscratch;
    w_mepc_d         = r_mepc;
    w_mcause_d       = r_mcause;
    w_mtval_d        = r_mtval;
    w_mcycle_d       = r_mcycle;
    w_minstret_d     = r_minstret;
    w_cy_inh_d       = r_cy_inh;
    w_ir_inh_d       = r_ir_inh;
    w_redirect_pc_d  = r_redirect_pc;

    // Counters run in both states; explicit writes below override.
    if (!r_cy_inh) w_mcycle_d = r_mcycle + XLEN'(1);
    if (i_retire && !i_stall && !r_ir_inh) w_minstret_d = r_minstret + XLEN'(1);

    unique case (r_state)
      StRun: begin
        if (w_take_exc || w_take_int) begin
          w_mstatus_mpie_d = r_mstatus_mie;
          w_mstatus_mie_d  = 1'b0;
          w_mstatus_mpp_d  = r_priv;
          w_priv_d         = PrivM;
          w_state_d        = StRedirect;
          if (w_take_exc) begin
            w_mepc_d        = {i_exc_pc[XLEN-1:2], 2'b00};
            w_mcause_d      = XLEN'(i_exc_cause);
            w_mtval_d       = i_exc_tval;
            w_redirect_pc_d = w_base;
          end else begin
            w_mepc_d        = {i_int_pc[XLEN-1:2], 2'b00};
            w_mcause_d      = {1'b1, (XLEN-1)'(w_int_code)};
            w_mtval_d       = '0;
            w_redirect_pc_d = w_int_target;
          end
        end else if (w_take_mret) begin
          w_priv_d         = r_mstatus_mpp;
          w_mstatus_mie_d  = r_mstatus_mpie;
          w_mstatus_mpie_d = 1'b1;
          w_mstatus_mpp_d  = 2'd0;
          w_redirect_pc_d  = r_mepc;
          w_state_d        = StRedirect;
        end else if (w_csr_wr) begin
          case (i_csr_wa)
            AddrMstatus: begin
              w_mstatus_mie_d  = i_csr_wd[3];
              w_mstatus_mpie_d = i_csr_wd[7];
              w_mstatus_mpp_d  = i_csr_wd[12:11];
            end
            AddrMie:      w_mie_d      = i_csr_wd & MieMask;
            AddrMtvec:    w_mtvec_d    = {i_csr_wd[XLEN-1:2], 1'b0,
                                          (VECTORED_EN != 0) ? i_csr_wd[0] : 1'b0};
            AddrMcntinh: begin
              w_cy_inh_d = i_csr_wd[0];
              w_ir_inh_d = i_csr_wd[2];
            end
            AddrMscratch: w_mscratch_d = i_csr_wd;
            AddrMepc:     w_mepc_d     = {i_csr_wd[XLEN-1:2], 2'b00};
            AddrMcause:   w_mcause_d   = i_csr_wd;
            AddrMtval:    w_mtval_d    = i_csr_wd;
            AddrMcycle:   w_mcycle_d   = i_csr_wd;
            AddrMinstret: w_minstret_d = i_csr_wd;
            default: ;    // mip and unimplemented addresses ignore writes
          endcase
        end
      end
      StRedirect: begin
        if (i_redirect_ready) w_state_d = StRun;
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state        <= StRun;
      r_priv         <= PrivM;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mstatus_mpp  <= 2'd0;
      r_mie          <= '0;
      r_mip_sw       <= 1'b0;
      r_mip_tm       <= 1'b0;
      r_mip_ex       <= 1'b0;
      r_mip_loc      <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
      r_mcycle       <= '0;
      r_minstret     <= '0;
      r_cy_inh       <= 1'b0;
      r_ir_inh       <= 1'b0;
      r_redirect_pc  <= '0;
    end else begin
      r_state        <= w_state_d;
      r_priv         <= w_priv_d;
      r_mstatus_mie  <= w_mstatus_mie_d;
      r_mstatus_mpie <= w_mstatus_mpie_d;
      r_mstatus_mpp  <= w_mstatus_mpp_d;
      r_mie          <= w_mie_d;
      // Interrupt levels are sampled every cycle, regardless of FSM state.
      r_mip_sw       <= i_swint;
      r_mip_tm       <= i_trint;
      r_mip_ex       <= i_exint;
      r_mip_loc      <= i_lirq;
      r_mtvec        <= w_mtvec_d;
      r_mscratch     <= w_mscratch_d;
      r_mepc         <= w_mepc_d;
      r_mcause       <= w_mcause_d;
      r_mtval        <= w_mtval_d;
      r_mcycle       <= w_mcycle_d;
      r_minstret     <= w_minstret_d;
      r_cy_inh       <= w_cy_inh_d;
      r_ir_inh       <= w_ir_inh_d;
      r_redirect_pc  <= w_redirect_pc_d;
    end
  end

  assign o_redirect_valid = (r_state == StRedirect);
  assign o_redirect_pc    = r_redirect_pc;
  assign o_int_pending    = w_int_pending;
  assign o_priv           = r_priv;

endmodule
